// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
// Purpose : groups the CPU write port, the transmitter handshake and the
//           FIFO status flags of uart_tx_fifo into one bundle.
// Signals :
//   wr_en/wr_data   CPU push strobe and byte
//   clr_ovf         clears the sticky overflow flag
//   tx_done         one-cycle end-of-stop-bit pulse from the transmitter
//   tx_start        one-cycle pulse, transmitter latches data_out on it
//   data_out        byte in flight, stable from tx_start to next tx_start
//   full/empty/count occupancy status (registered)
//   busy            FSM is in BUSY (doubles as the FSM state view)
//   overflow        sticky: a write was dropped because the FIFO was full
//   tx_idle_int     one-cycle pulse when the last queued byte completes
// Handshake: the CPU may write any cycle; a write seen while full=1 is
//   dropped. tx_start/tx_done form a start/complete pair: after tx_start the
//   FIFO waits in BUSY until exactly one tx_done, and ignores tx_done in IDLE.
// Modports: master = CPU + transmitter side, slave = the FIFO.
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            wr_en;
    logic [DBIT-1:0] wr_data;
    logic            clr_ovf;
    logic            tx_done;
    logic            tx_start;
    logic [DBIT-1:0] data_out;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    logic            busy;
    logic            overflow;
    logic            tx_idle_int;

    modport master (
        output wr_en, wr_data, clr_ovf, tx_done,
        input  tx_start, data_out, full, empty, count, busy, overflow,
               tx_idle_int
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf, tx_done,
        output tx_start, data_out, full, empty, count, busy, overflow,
               tx_idle_int
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Purpose : transmit FIFO in front of a UART transmitter. Bytes written by
//           the CPU are queued in a DEPTH x DBIT register array and handed to
//           the transmitter one at a time with a tx_start pulse; the next
//           byte is released only after the transmitter returns tx_done.
// Ports   :
//   clk    rising-edge clock for all state
//   reset  synchronous, active-high; empties the FIFO and returns to IDLE
//   bus    uart_tx_fifo_if.slave (see interface header for signal list)
// Parameters: DBIT character width; DEPTH entries, power of two, >= 2.
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DBIT  = 8,
    parameter int DEPTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_tx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // busy mirrors the state register, so it is the FSM's external view.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [DBIT-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic [DBIT-1:0] r_data_out;
    logic            r_tx_start;
    logic            r_overflow;
    logic            r_tx_idle_int;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_drop;
    logic            w_pop;
    logic            w_idle_int;

    // Flags come from the registered count only, so full is judged before
    // any pop happening in the same cycle: a write while full is dropped
    // even if a slot frees up on that edge.
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.wr_en && !w_full;
    assign w_drop  = bus.wr_en && w_full;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_idle_int   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // tx_done is ignored here; only a non-empty FIFO matters.
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                // Returning to IDLE first (rather than popping directly)
                // guarantees one idle cycle between tx_done and tx_start.
                if (bus.tx_done) begin
                    w_state_next = S_IDLE;
                    w_idle_int   = (r_count == '0) && !w_push;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------ storage
    // Array is not reset; pointers and count define which entries are valid.
    // rd_ptr == wr_ptr only when empty (no pop) or full (no push), so a push
    // and a pop never touch the same entry in one cycle.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_data_out    <= '0;
            r_tx_start    <= 1'b0;
            r_overflow    <= 1'b0;
            r_tx_idle_int <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + AW'(1);
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_tx_start    <= w_pop;
            r_tx_idle_int <= w_idle_int;
            // A dropped write in the same cycle as clr_ovf keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_ovf) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.tx_start    = r_tx_start;
    assign bus.data_out    = r_data_out;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.count       = r_count;
    assign bus.busy        = (r_state == S_BUSY);
    assign bus.overflow    = r_overflow;
    assign bus.tx_idle_int = r_tx_idle_int;

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;
  localparam int DBIT  = 8;
  localparam int DEPTH = 16;

  // ---------------------------------------------------------- clock/reset
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  uart_tx_fifo_if #(.DBIT(DBIT), .DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DBIT(DBIT), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  // tx_done is the OR of the automatic transmitter responder and manual pulses.
  logic resp_done;
  logic man_done;
  assign bus.tx_done = resp_done | man_done;

  // ------------------------------------------------------------ counters
  int checks;
  int errors;
  bit mon_en;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------ reference model
  // Behavioural view: the FIFO is a queue of bytes plus "a character is on
  // the wire" flag. Evaluated at each rising edge from the inputs presented.
  logic [DBIT-1:0] m_q[$];
  logic [DBIT-1:0] exp_q[$];
  bit              m_busy;
  bit              m_ovf;
  bit              m_start;
  bit              m_idle;
  logic [DBIT-1:0] m_dout;
  bit              mdl_push;
  bit              mdl_drop;
  bit              mdl_pop;
  bit              mdl_idle;

  initial begin
    m_busy = 0; m_ovf = 0; m_start = 0; m_idle = 0; m_dout = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        exp_q.delete();
        m_busy = 0; m_ovf = 0; m_start = 0; m_idle = 0; m_dout = '0;
      end else begin
        mdl_push = bus.wr_en && (m_q.size() < DEPTH);
        mdl_drop = bus.wr_en && (m_q.size() == DEPTH);
        mdl_pop  = !m_busy && (m_q.size() > 0);
        mdl_idle = m_busy && bus.tx_done && (m_q.size() == 0) && !mdl_push;
        if (mdl_pop) m_dout = m_q.pop_front();
        if (mdl_push) begin
          m_q.push_back(bus.wr_data);
          exp_q.push_back(bus.wr_data);
        end
        if (mdl_pop) m_busy = 1;
        else if (m_busy && bus.tx_done) m_busy = 0;
        if (mdl_drop) m_ovf = 1;
        else if (bus.clr_ovf) m_ovf = 0;
        m_start = mdl_pop;
        m_idle  = mdl_idle;
      end
    end
  end

  // ------------------------------------------------------------- monitor
  logic [DBIT-1:0] sb_exp;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("count", int'(bus.count), m_q.size());
        check("full", int'(bus.full), int'(m_q.size() == DEPTH));
        check("empty", int'(bus.empty), int'(m_q.size() == 0));
        check("busy", int'(bus.busy), int'(m_busy));
        check("overflow", int'(bus.overflow), int'(m_ovf));
        check("tx_start", int'(bus.tx_start), int'(m_start));
        check("tx_idle_int", int'(bus.tx_idle_int), int'(m_idle));
        check("data_out", int'(bus.data_out), int'(m_dout));
        if (bus.tx_start) begin
          if (exp_q.size() == 0) begin
            check("sb_unexpected_start", 1, 0);
          end else begin
            sb_exp = exp_q.pop_front();
            check("sb_data", int'(bus.data_out), int'(sb_exp));
          end
        end
      end
    end
  end

  // -------------------------------------------------- transmitter model
  bit resp_en;
  int lat_lo;
  int lat_hi;
  int lat;

  initial begin
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && bus.tx_start) begin
        lat = int'($urandom_range(lat_hi, lat_lo));
        repeat (lat - 1) @(negedge clk);
        resp_done = 1'b1;
        @(negedge clk);
        resp_done = 1'b0;
      end
    end
  end

  // -------------------------------------------------------- driver tasks
  task automatic write_byte(input logic [DBIT-1:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_done();
    man_done = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.clr_ovf = 1'b1;
    @(negedge clk);
    bus.clr_ovf = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000; i++) begin
      if (m_q.size() == 0 && !m_busy && exp_q.size() == 0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    check(name, int'(ok), 1);
    repeat (3) @(negedge clk);
  endtask

  // ------------------------------------------------------------ stimulus
  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.clr_ovf = 1'b0;
    man_done    = 1'b0;
    resp_en     = 0;
    lat_lo      = 1;
    lat_hi      = 1;
    mon_en      = 0;
    checks      = 0;
    errors      = 0;

    @(negedge clk);
    mon_en = 1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // tx_done while idle is ignored
    pulse_done();
    repeat (2) @(negedge clk);

    // single byte
    resp_en = 1; lat_lo = 5; lat_hi = 5;
    write_byte(8'h55);
    wait_drain("drain_single");

    // burst of three, fixed 20-cycle transmitter
    lat_lo = 20; lat_hi = 20;
    write_byte(8'hA1);
    write_byte(8'hA2);
    write_byte(8'hA3);
    wait_drain("drain_burst");

    // overflow: 18 writes with transmitter stalled
    resp_en = 0;
    for (int i = 0; i < 18; i++) write_byte(8'(i));
    @(negedge clk);
    pulse_clr();
    @(negedge clk);
    resp_en = 1; lat_lo = 1; lat_hi = 8;
    pulse_done();
    wait_drain("drain_overflow");

    // full plus write on the cycle the FSM pops
    resp_en = 0;
    for (int i = 0; i < 17; i++) write_byte(8'(8'h30 + i));
    man_done = 1'b1;
    @(negedge clk);
    man_done    = 1'b0;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'h77;
    @(negedge clk);
    bus.wr_en   = 1'b0;
    @(negedge clk);
    pulse_clr();
    resp_en = 1; lat_lo = 1; lat_hi = 4;
    pulse_done();
    wait_drain("drain_full_pop");

    // reset mid-flight, with a write during the reset cycle
    resp_en = 0;
    for (int i = 0; i < 5; i++) write_byte(8'(8'hC0 + i));
    repeat (2) @(negedge clk);
    rst         = 1'b1;
    bus.wr_en   = 1'b1;
    bus.wr_data = 8'hEE;
    @(negedge clk);
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    pulse_done();
    repeat (10) @(negedge clk);

    // pointer wrap: 40 incrementing bytes, random gaps and latency
    resp_en = 1; lat_lo = 1; lat_hi = 30;
    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      for (int w = 0; w < 200 && m_q.size() >= DEPTH; w++) @(negedge clk);
      write_byte(8'(n));
    end
    wait_drain("drain_wrap");

    @(posedge clk);
    mon_en = 0;
    check("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DBIT, default 8: data width of one UART character.
REQ-002 Parameter DEPTH, default 16: number of FIFO entries; SHALL be a power of two, at least 2.
REQ-003 clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1: synchronous, active-high reset.
REQ-005 wr_en  input  1: CPU write strobe; one byte is pushed per cycle when high.
REQ-006 wr_data  input  DBIT: byte to push.
REQ-007 clr_ovf  input  1: clears the overflow flag.
REQ-008 tx_done  input  1: single-cycle pulse from the transmitter, in the clk domain, marking end of the stop bit.
REQ-009 tx_start  output  1: single-cycle pulse; transmitter SHALL latch data_out on it.
REQ-010 data_out  output  DBIT: byte being transmitted; held stable from tx_start until the next tx_start.
REQ-011 full  output  1: FIFO holds DEPTH entries.
REQ-012 empty  output  1: FIFO holds 0 entries.
REQ-013 count  output  log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-014 busy  output  1: a character is in flight (state BUSY).
REQ-015 overflow  output  1: sticky flag; a write was dropped.
REQ-016 tx_idle_int  output  1: single-cycle pulse when the last queued character completes.

Function
REQ-017 Storage: DEPTH x DBIT register array, read and write pointers of log2(DEPTH) bits wrapping modulo DEPTH, and a separate occupancy counter.
REQ-018 full, empty and count SHALL be derived from registered state only and reflect the state after the previous edge.
REQ-019 Push: wr_en=1 and full=0 writes wr_data at wr_ptr and increments wr_ptr.
REQ-020 Write while full: wr_en=1 with full=1 SHALL be dropped, leaving pointers and array unchanged and setting overflow=1.
REQ-021 REQ-020 applies even when a pop occurs in the same cycle; full is evaluated before that cycle's pop.
REQ-022 FSM states: IDLE, BUSY.
REQ-023 IDLE with empty=0: pop the head, meaning data_out <= mem[rd_ptr], rd_ptr increments, tx_start <= 1 for the next cycle only, next state BUSY.
REQ-024 IDLE with empty=1: remain IDLE with tx_start=0.
REQ-025 BUSY: tx_done=1 returns to IDLE; otherwise stay in BUSY.
REQ-026 Inter-character gap: a pending byte SHALL be popped in the first IDLE cycle after tx_done, giving a minimum of one idle cycle between tx_done and the next tx_start edge.
REQ-027 tx_done in IDLE SHALL be ignored: no state, pointer or interrupt change.
REQ-028 Simultaneous push and pop: count SHALL be unchanged and both pointers SHALL advance.
REQ-029 count update: +1 on push only, -1 on pop only; it SHALL never exceed DEPTH or go below 0.
REQ-030 Push into an empty FIFO at edge N: empty=0 after edge N, pop at edge N+1, tx_start=1 during cycle N+1..N+2, busy=1 from edge N+1.
REQ-031 tx_idle_int SHALL pulse for one cycle on the edge after a tx_done in BUSY when count=0 and no push occurred in that cycle.
REQ-032 overflow SHALL be cleared by clr_ovf=1 on the next edge.
REQ-033 If clr_ovf and a dropped write occur in the same cycle, set SHALL win and overflow=1.
REQ-034 busy SHALL equal (state==BUSY).

Reset
REQ-035 reset=1 at an edge SHALL set rd_ptr=0, wr_ptr=0, count=0 and state=IDLE.
REQ-036 reset=1 at an edge SHALL set outputs to tx_start=0, data_out=0, overflow=0, tx_idle_int=0, busy=0, empty=1, full=0.
REQ-037 Reset mid-transmission SHALL discard all queued bytes and return to IDLE; a later tx_done pulse SHALL be ignored per REQ-027.
REQ-038 Writes during a reset cycle SHALL be dropped and SHALL not set overflow.
REQ-039 Array contents need not be reset.

Verification
REQ-040 Single byte: write 0x55 at edge N -> tx_start pulse in cycle N+1, data_out=0x55, busy=1; tx_done pulse -> busy=0 next edge, tx_idle_int pulses once, empty=1.
REQ-041 Burst of 3: writes 0xA1, 0xA2, 0xA3 on consecutive cycles, tx_done returned 20 cycles after each tx_start -> three tx_start pulses in order A1, A2, A3, each at least one cycle after the prior tx_done; tx_idle_int only after A3.
REQ-042 Overflow: with no tx_done returned, write 18 bytes 0x00..0x11 (DEPTH=16) -> first byte popped; count=15, then 16 with full=1; overflow=1; clr_ovf -> overflow=0; drain outputs 0x00..0x10 exactly, with the last write 0x11 dropped.
REQ-043 Full plus simultaneous pop: with full=1, assert wr_en=1 with 0x77 on the cycle the FSM pops -> write dropped, overflow=1, count=15.
REQ-044 Reset mid-flight: 4 bytes queued and BUSY, reset for 1 cycle -> count=0, empty=1, busy=0; subsequent tx_done produces no tx_start and no tx_idle_int.
REQ-045 Pointer wrap: 40 writes and drains of incrementing bytes with random tx_done latency of 1..30 cycles -> output sequence equals input sequence and count never exceeds 16.
